alu_16_result_queue: RTL and testbench

- Downstream stage of the 16-bit add/sub/and/or ALU.
- Captures each ALU result together with the op code that produced it and derives zero/negative flags.
- Buffers entries in a small FIFO with valid/ready handshakes on both sides, so a stalling consumer (register-file writeback or flag register) never loses a result.

---
 rtl/alu_16_result_queue.sv | 93 +++++++++
 tb/tb_alu_16_result_queue.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_16_result_queue.sv
// Result queue behind the 16-bit ALU: stores y/op with zero/neg flags computed at write time,
// and presents the head entry to a consumer that may stall.
module alu_16_result_queue #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [15:0]             in_y,
  input  logic [1:0]              in_op,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [15:0]             out_y,
  output logic [1:0]              out_op,
  output logic                    out_zero,
  output logic                    out_neg,
  output logic [$clog2(DEPTH):0]  level,
  output logic [CNT_W-1:0]        accepted_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  logic [15:0]      mem_y    [DEPTH];
  logic [1:0]       mem_op   [DEPTH];
  logic             mem_zero [DEPTH];
  logic             mem_neg  [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push;
  logic             pop;

  // in_ready depends only on registered level, so out_ready never reaches it combinationally
  assign in_ready  = (level != FULL_LVL);
  assign out_valid = (level != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      level        <= '0;
      accepted_cnt <= '0;
    end else if (flush) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      level        <= '0;
      accepted_cnt <= '0;
    end else begin
      if (push) begin
        wr_ptr       <= wr_ptr + PTR_W'(1);
        accepted_cnt <= accepted_cnt + CNT_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push && !pop) begin
        level <= level + LVL_W'(1);
      end else if (pop && !push) begin
        level <= level - LVL_W'(1);
      end
    end
  end

  // Storage needs no reset: stale contents are masked by the out_valid forcing below
  always_ff @(posedge clk) begin
    if (push) begin
      mem_y[wr_ptr]    <= in_y;
      mem_op[wr_ptr]   <= in_op;
      mem_zero[wr_ptr] <= (in_y == 16'h0000);
      mem_neg[wr_ptr]  <= in_y[15];
    end
  end

  always_comb begin
    out_y    = '0;
    out_op   = '0;
    out_zero = 1'b0;
    out_neg  = 1'b0;
    if (out_valid) begin
      out_y    = mem_y[rd_ptr];
      out_op   = mem_op[rd_ptr];
      out_zero = mem_zero[rd_ptr];
      out_neg  = mem_neg[rd_ptr];
    end
  end

endmodule

// File: tb/tb_alu_16_result_queue.sv
// Bench for alu_16_result_queue: directed vector table, hand-written corner sequences and
// random traffic compared against a queue-based reference model.
module tb_alu_16_result_queue;

  localparam int DEPTH = 4;
  localparam int CNT_W = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_y = '0;
  logic [1:0]  in_op = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_y;
  logic [1:0]  out_op;
  logic        out_zero;
  logic        out_neg;
  logic [2:0]  level;
  logic [CNT_W-1:0] accepted_cnt;

  alu_16_result_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_y(in_y), .in_op(in_op),
    .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y), .out_op(out_op),
    .out_zero(out_zero), .out_neg(out_neg), .level(level), .accepted_cnt(accepted_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [15:0] y;
    logic [1:0]  op;
  } ent_t;
  ent_t mq[$];
  logic [CNT_W-1:0] m_cnt = '0;

  typedef struct {
    logic        iv;
    logic [15:0] y;
    logic [1:0]  op;
    logic        ordy;
    logic        fl;
    int          e_lvl;
    logic        e_vld;
    logic        e_rdy;
    logic [15:0] e_y;
    logic [1:0]  e_op;
    logic        e_z;
    logic        e_n;
    int          e_cnt;
  } vec_t;
  vec_t vecs[$];

  function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic void add_vec(logic iv, logic [15:0] y, logic [1:0] op, logic ordy, logic fl,
                                  int lvl, logic vld, logic rdy, logic [15:0] ey, logic [1:0] eop,
                                  logic ez, logic en, int cnt);
    vec_t v;
    v = '{iv, y, op, ordy, fl, lvl, vld, rdy, ey, eop, ez, en, cnt};
    vecs.push_back(v);
  endfunction

  // Reference model: a plain queue with the handshake rules applied to the pre-edge state
  function automatic void model_update();
    int  sz;
    bit  do_push;
    bit  do_pop;
    sz = mq.size();
    if (flush) begin
      mq.delete();
      m_cnt = '0;
      return;
    end
    do_pop  = out_ready && (sz > 0);
    do_push = in_valid && (sz < DEPTH);
    if (do_pop) void'(mq.pop_front());
    if (do_push) begin
      mq.push_back('{in_y, in_op});
      m_cnt = m_cnt + 1'b1;
    end
  endfunction

  function automatic void check_model();
    logic [15:0] ey;
    logic [1:0]  eop;
    logic        ev;
    ev  = (mq.size() != 0);
    ey  = ev ? mq[0].y : 16'h0;
    eop = ev ? mq[0].op : 2'b00;
    check("m_level", 32'(level), 32'(mq.size()));
    check("m_out_valid", 32'(out_valid), 32'(ev));
    check("m_in_ready", 32'(in_ready), 32'(mq.size() != DEPTH));
    check("m_out_y", 32'(out_y), 32'(ey));
    check("m_out_op", 32'(out_op), 32'(eop));
    check("m_out_zero", 32'(out_zero), 32'(ev && ey == 16'h0));
    check("m_out_neg", 32'(out_neg), 32'(ev && ey[15]));
    check("m_cnt", 32'(accepted_cnt), 32'(m_cnt));
  endfunction

  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    check_model();
  endtask

  task automatic set_in(logic iv, logic [15:0] y, logic [1:0] op, logic ordy, logic fl);
    in_valid  = iv;
    in_y      = y;
    in_op     = op;
    out_ready = ordy;
    flush     = fl;
  endtask

  initial begin
    // Single push of a zero result, then pop
    add_vec(1, 16'h0000, 2'b01, 0, 0,  1, 1, 1, 16'h0000, 2'b01, 1, 0, 1);
    add_vec(0, 16'h0000, 2'b00, 1, 0,  0, 0, 1, 16'h0000, 2'b00, 0, 0, 1);
    add_vec(0, 16'h0000, 2'b00, 0, 1,  0, 0, 1, 16'h0000, 2'b00, 0, 0, 0);
    // Fill with the consumer stalled; the fifth offer is ignored
    add_vec(1, 16'h8001, 2'b00, 0, 0,  1, 1, 1, 16'h8001, 2'b00, 0, 1, 1);
    add_vec(1, 16'h0002, 2'b01, 0, 0,  2, 1, 1, 16'h8001, 2'b00, 0, 1, 2);
    add_vec(1, 16'h0003, 2'b10, 0, 0,  3, 1, 1, 16'h8001, 2'b00, 0, 1, 3);
    add_vec(1, 16'h0004, 2'b11, 0, 0,  4, 1, 0, 16'h8001, 2'b00, 0, 1, 4);
    add_vec(1, 16'h0005, 2'b00, 0, 0,  4, 1, 0, 16'h8001, 2'b00, 0, 1, 4);
    add_vec(0, 16'h0000, 2'b00, 1, 0,  3, 1, 1, 16'h0002, 2'b01, 0, 0, 4);
    add_vec(0, 16'h0000, 2'b00, 1, 0,  2, 1, 1, 16'h0003, 2'b10, 0, 0, 4);
    add_vec(0, 16'h0000, 2'b00, 1, 0,  1, 1, 1, 16'h0004, 2'b11, 0, 0, 4);
    add_vec(0, 16'h0000, 2'b00, 1, 0,  0, 0, 1, 16'h0000, 2'b00, 0, 0, 4);
    // Full with simultaneous pop and offer: offer dropped, next push accepted
    add_vec(1, 16'h1111, 2'b00, 0, 0,  1, 1, 1, 16'h1111, 2'b00, 0, 0, 5);
    add_vec(1, 16'h2222, 2'b01, 0, 0,  2, 1, 1, 16'h1111, 2'b00, 0, 0, 6);
    add_vec(1, 16'h3333, 2'b10, 0, 0,  3, 1, 1, 16'h1111, 2'b00, 0, 0, 7);
    add_vec(1, 16'h4444, 2'b11, 0, 0,  4, 1, 0, 16'h1111, 2'b00, 0, 0, 8);
    add_vec(1, 16'h5555, 2'b00, 1, 0,  3, 1, 1, 16'h2222, 2'b01, 0, 0, 8);
    add_vec(1, 16'h6666, 2'b10, 0, 0,  4, 1, 0, 16'h2222, 2'b01, 0, 0, 9);
    add_vec(0, 16'h0000, 2'b00, 1, 0,  3, 1, 1, 16'h3333, 2'b10, 0, 0, 9);
    add_vec(0, 16'h0000, 2'b00, 1, 0,  2, 1, 1, 16'h4444, 2'b11, 0, 0, 9);
    add_vec(0, 16'h0000, 2'b00, 1, 0,  1, 1, 1, 16'h6666, 2'b10, 0, 0, 9);
    add_vec(0, 16'h0000, 2'b00, 1, 0,  0, 0, 1, 16'h0000, 2'b00, 0, 0, 9);
    // Pop request on an empty queue changes nothing
    add_vec(0, 16'h0000, 2'b00, 1, 0,  0, 0, 1, 16'h0000, 2'b00, 0, 0, 9);

    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_level", 32'(level), 32'd0);
    check("rst_out_y", 32'(out_y), 32'd0);
    check("rst_cnt", 32'(accepted_cnt), 32'd0);

    foreach (vecs[i]) begin
      set_in(vecs[i].iv, vecs[i].y, vecs[i].op, vecs[i].ordy, vecs[i].fl);
      step();
      check($sformatf("v%0d_level", i), 32'(level), 32'(vecs[i].e_lvl));
      check($sformatf("v%0d_valid", i), 32'(out_valid), 32'(vecs[i].e_vld));
      check($sformatf("v%0d_ready", i), 32'(in_ready), 32'(vecs[i].e_rdy));
      check($sformatf("v%0d_y", i), 32'(out_y), 32'(vecs[i].e_y));
      check($sformatf("v%0d_op", i), 32'(out_op), 32'(vecs[i].e_op));
      check($sformatf("v%0d_zero", i), 32'(out_zero), 32'(vecs[i].e_z));
      check($sformatf("v%0d_neg", i), 32'(out_neg), 32'(vecs[i].e_n));
      check($sformatf("v%0d_cnt", i), 32'(accepted_cnt), 32'(vecs[i].e_cnt));
    end

    // Streaming: 20 back-to-back transfers, level held at 1
    set_in(0, 16'h0, 2'b00, 0, 1);
    step();
    for (int i = 0; i < 20; i++) begin
      set_in(1, 16'(i + 16'h0100), 2'(i), 1, 0);
      step();
      check("stream_level", 32'(level), 32'd1);
      check("stream_y", 32'(out_y), 32'(i + 16'h0100));
    end
    check("stream_cnt", 32'(accepted_cnt), 32'd20);
    set_in(0, 16'h0, 2'b00, 1, 0);
    step();
    check("stream_drain", 32'(level), 32'd0);

    // Flush with three queued and a concurrent offer
    for (int i = 0; i < 3; i++) begin
      set_in(1, 16'(16'hA000 + i), 2'b11, 0, 0);
      step();
    end
    set_in(1, 16'hBEEF, 2'b01, 0, 1);
    step();
    check("flush_level", 32'(level), 32'd0);
    check("flush_cnt", 32'(accepted_cnt), 32'd0);
    check("flush_valid", 32'(out_valid), 32'd0);

    // Asynchronous reset in mid-cycle with two entries queued
    for (int i = 0; i < 2; i++) begin
      set_in(1, 16'(16'hC000 + i), 2'b10, 0, 0);
      step();
    end
    set_in(0, 16'h0, 2'b00, 0, 0);
    #2 rst = 1'b1;
    #1;
    check("arst_valid", 32'(out_valid), 32'd0);
    check("arst_level", 32'(level), 32'd0);
    check("arst_ready", 32'(in_ready), 32'd1);
    check("arst_y", 32'(out_y), 32'd0);
    check("arst_cnt", 32'(accepted_cnt), 32'd0);
    mq.delete();
    m_cnt = '0;
    @(negedge clk);
    rst = 1'b0;
    step();

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      set_in(1'($urandom_range(0, 1)), 16'($urandom), 2'($urandom),
             1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 40) == 0));
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
